// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: reset vector, FSM
// encoding and instruction field positions.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int TARGET_MSB = 25;
  localparam int IMM_MSB    = 15;

  // Branch displacement: sign-extended 16-bit word offset turned into bytes.
  function automatic logic [31:0] branch_offset(input logic [IMM_MSB:0] imm);
    return {{14{imm[IMM_MSB]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit and memory.
// imem_req is held high with a stable imem_addr until a cycle with
// imem_ack=1; that cycle completes the read and imem_rdata is valid in it.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_npc.sv
// Next-PC selection: jump beats taken branch beats sequential PC+4.
module npc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] PC4,
  input  logic [31:0] Instr,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic unused_opcode_bits;
  assign unused_opcode_bits = ^Instr[OPCODE_MSB:OPCODE_LSB];

  always_comb begin
    next_pc = PC4;
    if (jump) begin
      next_pc = {PC4[31:28], Instr[TARGET_MSB:0], 2'b00};
    end else if (Branch && Zero) begin
      next_pc = PC4 + branch_offset(Instr[IMM_MSB:0]);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests the word at PC, holds it until the
// downstream stage retires it, then moves PC to the selected next address.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  imem,
  output logic          inst_valid,
  input  logic          inst_accept,
  input  logic          Branch,
  input  logic          Zero,
  input  logic          jump,
  output logic [31:0]   Instr,
  output logic [5:0]    OpCode,
  output logic [5:0]    funct,
  output logic [31:0]   PC,
  output logic [31:0]   PC4,
  output state_t        state_dbg
);

  state_t      state;
  state_t      state_nxt;
  logic        load_instr;
  logic        advance_pc;
  logic [31:0] next_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    imem.imem_req = 1'b0;
    load_instr    = 1'b0;
    advance_pc    = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          load_instr = 1'b1;
          state_nxt  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Branch/Zero/jump only matter here, via next_pc.
        if (inst_accept) begin
          advance_pc = 1'b1;
          state_nxt  = ST_FETCH;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC         <= RESET_VECTOR;
      Instr      <= 32'h0;
      inst_valid <= 1'b0;
    end else begin
      if (load_instr) begin
        Instr      <= imem.imem_rdata;
        inst_valid <= 1'b1;
      end
      if (advance_pc) begin
        PC         <= next_pc;
        inst_valid <= 1'b0;
      end
    end
  end

  npc u_npc (
    .PC4     (PC4),
    .Instr   (Instr),
    .Branch  (Branch),
    .Zero    (Zero),
    .jump    (jump),
    .next_pc (next_pc)
  );

  assign PC4            = PC + 32'd4;
  assign imem.imem_addr = PC;
  assign OpCode         = Instr[OPCODE_MSB:OPCODE_LSB];
  assign funct          = Instr[FUNCT_MSB:FUNCT_LSB];
  assign state_dbg      = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: the bench plays instruction memory and the
// downstream stage, tracking the expected PC and fetched words.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic        inst_accept;
  logic        Branch;
  logic        Zero;
  logic        jump;
  logic [31:0] Instr;
  logic [5:0]  OpCode;
  logic [5:0]  funct;
  logic [31:0] PC;
  logic [31:0] PC4;
  state_t      state_dbg;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .inst_valid  (inst_valid),
    .inst_accept (inst_accept),
    .Branch      (Branch),
    .Zero        (Zero),
    .jump        (jump),
    .Instr       (Instr),
    .OpCode      (OpCode),
    .funct       (funct),
    .PC          (PC),
    .PC4         (PC4),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] held_instr;
  logic [31:0] npc_got;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] ins,
                                            input logic br, input logic zr, input logic jp);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (jp) return {p4[31:28], ins[25:0], 2'b00};
    if (br && zr) return p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
    return p4;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("req_timeout", 32'd0, 32'd1);
  endtask

  // memory driver: answer the pending request after 'waits' empty cycles
  task automatic do_fetch(input logic [31:0] rdata, input int waits);
    bit          ok;
    logic [31:0] e;
    wait_req(ok);
    if (!ok) return;
    check("fetch_addr", bus.imem_addr, model_pc);
    for (int i = 0; i < waits; i++) begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      Branch         = 1'($urandom_range(0, 1));
      Zero           = 1'($urandom_range(0, 1));
      jump           = 1'($urandom_range(0, 1));
      inst_accept    = 1'($urandom_range(0, 1));
      tick();
      check("wait_req", 32'(bus.imem_req), 32'd1);
      check("wait_addr", bus.imem_addr, model_pc);
      check("wait_valid", 32'(inst_valid), 32'd0);
    end
    inst_accept    = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    exp_q.push_back(rdata);
    tick();
    bus.imem_ack = 1'b0;
    Branch       = 1'b0;
    Zero         = 1'b0;
    jump         = 1'b0;
    check("fetch_valid", 32'(inst_valid), 32'd1);
    check("fetch_req_low", 32'(bus.imem_req), 32'd0);
    check("fetch_state", 32'(state_dbg), 32'(ST_HOLD));
    e = exp_q.pop_front();
    check("fetch_instr", Instr, e);
    check("fetch_opcode", 32'(OpCode), {26'd0, e[31:26]});
    check("fetch_funct", 32'(funct), {26'd0, e[5:0]});
    check("fetch_pc", PC, model_pc);
    check("fetch_pc4", PC4, model_pc + 32'd4);
    held_instr = e;
  endtask

  // downstream driver: stall, then retire with the given branch/jump decode
  task automatic do_accept(input int stall, input logic br, input logic zr, input logic jp,
                           output logic [31:0] npc_out);
    logic [31:0] nxt;
    for (int i = 0; i < stall; i++) begin
      bus.imem_ack   = 1'($urandom_range(0, 1));
      bus.imem_rdata = $urandom;
      Branch         = 1'($urandom_range(0, 1));
      Zero           = 1'($urandom_range(0, 1));
      jump           = 1'($urandom_range(0, 1));
      inst_accept    = 1'b0;
      tick();
      check("stall_req", 32'(bus.imem_req), 32'd0);
      check("stall_valid", 32'(inst_valid), 32'd1);
      check("stall_instr", Instr, held_instr);
      check("stall_pc", PC, model_pc);
    end
    bus.imem_ack = 1'b0;
    inst_accept  = 1'b1;
    Branch       = br;
    Zero         = zr;
    jump         = jp;
    nxt = model_npc(model_pc, held_instr, br, zr, jp);
    tick();
    inst_accept = 1'b0;
    Branch      = 1'b0;
    Zero        = 1'b0;
    jump        = 1'b0;
    check("accept_valid", 32'(inst_valid), 32'd0);
    check("accept_req", 32'(bus.imem_req), 32'd1);
    check("accept_addr", bus.imem_addr, nxt);
    model_pc = nxt;
    npc_out  = nxt;
  endtask

  initial begin
    logic [31:0] r;
    bit          ok;
    rst            = 1'b1;
    inst_accept    = 1'b0;
    Branch         = 1'b0;
    Zero           = 1'b0;
    jump           = 1'b0;
    bus.imem_ack   = 1'b1;
    r              = $urandom;
    bus.imem_rdata = r;
    repeat (3) tick();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_instr", Instr, 32'd0);
    check("rst_pc", PC, 32'h0000_3000);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // reset release with ack held high: zero-wait first fetch
    rst = 1'b0;
    tick();
    check("rel_req", 32'(bus.imem_req), 32'd1);
    check("rel_addr", bus.imem_addr, 32'h0000_3000);
    check("rel_valid", 32'(inst_valid), 32'd0);
    exp_q.push_back(r);
    tick();
    bus.imem_ack = 1'b0;
    check("rel_inst_valid", 32'(inst_valid), 32'd1);
    check("rel_instr", Instr, exp_q.pop_front());
    model_pc   = 32'h0000_3000;
    held_instr = r;

    do_accept(0, 1'b0, 1'b0, 1'b0, npc_got);
    check("seq_3004", npc_got, 32'h0000_3004);
    do_fetch($urandom, 3);
    do_accept(1, 1'b0, 1'b0, 1'b0, npc_got);
    check("seq_3008", npc_got, 32'h0000_3008);
    do_fetch({16'($urandom_range(0, 65535)), 16'hFFFE}, 0);
    do_accept(2, 1'b1, 1'b1, 1'b0, npc_got);
    check("branch_taken", npc_got, 32'h0000_3004);
    do_fetch($urandom, 1);
    do_accept(5, 1'b0, 1'b0, 1'b0, npc_got);
    do_fetch({16'h1000, 16'hFFFE}, 2);
    do_accept(0, 1'b1, 1'b0, 1'b0, npc_got);
    check("branch_not_taken", npc_got, 32'h0000_300C);
    do_fetch($urandom, 0);
    do_accept(0, 1'b0, 1'b0, 1'b0, npc_got);
    do_fetch({6'h02, 26'h000_0C40}, 0);
    do_accept(1, 1'b1, 1'b1, 1'b1, npc_got);
    check("jump_wins", npc_got, 32'h0000_3100);
    do_fetch({6'h04, 10'h0, 16'h8000}, 1);
    do_accept(0, 1'b1, 1'b1, 1'b0, npc_got);
    check("branch_wrap_low", npc_got, 32'hFFFE_3104);
    do_fetch({6'h02, 26'h3FF_FFFF}, 0);
    do_accept(0, 1'b0, 1'b0, 1'b1, npc_got);
    check("jump_top", npc_got, 32'hFFFF_FFFC);
    do_fetch($urandom, 0);
    do_accept(0, 1'b0, 1'b0, 1'b0, npc_got);
    check("pc_wrap", npc_got, 32'h0000_0000);

    for (int i = 0; i < 10; i++) begin
      do_fetch($urandom, $urandom_range(0, 3));
      do_accept($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), npc_got);
    end

    // reset while a fetch waits, with an ack arriving alongside it
    wait_req(ok);
    bus.imem_ack = 1'b0;
    tick();
    rst            = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = $urandom;
    #1;
    check("midrst_req", 32'(bus.imem_req), 32'd0);
    check("midrst_valid", 32'(inst_valid), 32'd0);
    check("midrst_instr", Instr, 32'd0);
    check("midrst_pc", PC, 32'h0000_3000);
    check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    rst = 1'b0;
    tick();
    check("late_ack_ignored", 32'(inst_valid), 32'd0);
    check("refetch_addr", bus.imem_addr, 32'h0000_3000);
    check("refetch_req", 32'(bus.imem_req), 32'd1);
    r              = $urandom;
    bus.imem_rdata = r;
    exp_q.push_back(r);
    tick();
    bus.imem_ack = 1'b0;
    check("refetch_valid", 32'(inst_valid), 32'd1);
    check("refetch_instr", Instr, exp_q.pop_front());
    model_pc   = 32'h0000_3000;
    held_instr = r;

    // reset while holding an instruction
    do_accept(2, 1'b0, 1'b0, 1'b0, npc_got);
    do_fetch($urandom, 1);
    rst = 1'b1;
    #1;
    check("holdrst_valid", 32'(inst_valid), 32'd0);
    check("holdrst_instr", Instr, 32'd0);
    check("holdrst_pc", PC, 32'h0000_3000);
    tick();
    rst      = 1'b0;
    model_pc = 32'h0000_3000;
    do_fetch($urandom, 2);
    do_accept(1, 1'b0, 1'b0, 1'b0, npc_got);
    check("holdrst_next", npc_got, 32'h0000_3004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
